// File: rtl/mem_rmw_ctrl.sv
// Byte-enabled request front end for the 1-cycle-read word RAM; partial stores become read-modify-write.
// Latency 1 cycle (full/empty write) or 2 cycles (read/partial write); one transaction outstanding, REQ_READY low until the response is taken.
module mem_rmw_ctrl #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [DWIDTH/8-1:0]   req_be,
    input  logic [DWIDTH-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic                  ram_web,
    output logic [AWIDTH-1:0]     ram_wad,
    output logic [DWIDTH-1:0]     ram_wdi,
    output logic [AWIDTH-1:0]     ram_rad,
    input  logic [DWIDTH-1:0]     ram_rdo
);

    localparam int NB = DWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RSP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                we_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [NB-1:0]       be_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [DWIDTH-1:0]   merged;
    logic                accept;
    logic                be_full;
    logic                be_none;
    logic                direct;

    assign accept  = req_valid && (state == IDLE);
    assign be_full = &req_be;
    assign be_none = ~|req_be;
    // Full-word and empty writes need no read, so they skip DATA entirely.
    assign direct  = req_we && (be_full || be_none);

    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdo[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        ram_web   = 1'b0;
        ram_wad   = addr_q;
        ram_wdi   = merged;
        ram_rad   = addr_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                ram_rad   = req_addr;
                ram_wad   = req_addr;
                ram_wdi   = req_wdata;
                if (accept) begin
                    if (direct) begin
                        ram_web   = be_full;
                        state_nxt = RSP;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                // Only reads and partial writes reach DATA, so we_q alone means merge-and-store.
                ram_web   = we_q;
                state_nxt = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // An abandoned read-modify-write must never reach the array.
        if (!rst_n) begin
            ram_web = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (direct) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            we_q    <= req_we;
                            addr_q  <= req_addr;
                            be_q    <= req_be;
                            wdata_q <= req_wdata;
                        end
                    end
                end
                DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? '0 : ram_rdo;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule
